// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative multiply/divide sequencer owning the HI/LO pair.
// Runs mult/multu/div/divu as a bit-serial loop (one bit per RUN cycle), handles
// mthi/mtlo in a single cycle, and serves mfhi/mflo reads from the live HI/LO.
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous active-high reset
//   start, op    operation request and code (000 mult, 001 multu, 010 div,
//                011 divu, 100 mthi, 101 mtlo, 11x no-op)
//   A, B         rs / rt operands
//   rd_req       mfhi/mflo read request; rd_sel selects HI (1) or LO (0)
//   rd_data      combinational HI/LO read mux
//   stall        busy & (start | rd_req)
//   busy         operation in flight (registered)
//   done         one-cycle pulse when HI/LO commit
//   div_by_zero  one-cycle pulse with done for a zero divisor
//   HI, LO       architectural result registers
module hilo_muldiv_ctrl #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            rd_req,
  input  logic            rd_sel,
  output logic [XLEN-1:0] rd_data,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(ITER - 1);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

  state_t                state;
  logic [CntW-1:0]       cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds dividend bits shifting out / quotient bits shifting in.
  logic [2*XLEN-1:0]     acc;
  logic [XLEN-1:0]       rem;
  logic [XLEN-1:0]       opa;      // |multiplicand|
  logic [XLEN-1:0]       opb;      // |divisor|
  logic                  neg_res;  // negate product / quotient at commit
  logic                  neg_rem;  // negate remainder at commit
  logic                  is_div;
  logic                  dbz_pend;

  logic                  signed_op;
  logic                  a_neg;
  logic                  b_neg;
  logic [XLEN-1:0]       abs_a;
  logic [XLEN-1:0]       abs_b;
  logic [XLEN:0]         msum;
  logic [XLEN:0]         part;
  logic [XLEN:0]         diff;
  logic                  q_bit;
  logic [XLEN-1:0]       rem_next;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       quo_fix;
  logic [XLEN-1:0]       rem_fix;

  always_comb begin
    signed_op = (op == OpMult) || (op == OpDiv);
    a_neg     = signed_op & A[XLEN-1];
    b_neg     = signed_op & B[XLEN-1];
    abs_a     = a_neg ? -A : A;
    abs_b     = b_neg ? -B : B;

    // Shift-add step: add multiplicand when the current multiplier LSB is set.
    msum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);

    // Restoring divide step. The partial remainder stays below the divisor, so
    // the XLEN+1-bit difference's top bit is set exactly when the trial fails.
    part     = {rem, acc[XLEN-1]};
    diff     = part - {1'b0, opb};
    q_bit    = ~diff[XLEN];
    rem_next = q_bit ? diff[XLEN-1:0] : part[XLEN-1:0];

    prod    = neg_res ? -acc : acc;
    quo_fix = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix = neg_rem ? -rem : rem;
  end

  assign rd_data = rd_sel ? HI : LO;
  assign stall   = busy & (start | rd_req);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= StIdle;
      cnt         <= '0;
      acc         <= '0;
      rem         <= '0;
      opa         <= '0;
      opb         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      is_div      <= 1'b0;
      dbz_pend    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            case (op)
              OpMult, OpMultu: begin
                opa      <= abs_a;
                acc      <= {{XLEN{1'b0}}, abs_b};
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= 1'b0;
                is_div   <= 1'b0;
                dbz_pend <= 1'b0;
                cnt      <= CntInit;
                busy     <= 1'b1;
                state    <= StRun;
              end
              OpDiv, OpDivu: begin
                opb     <= abs_b;
                acc     <= {{XLEN{1'b0}}, abs_a};
                rem     <= '0;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                is_div  <= 1'b1;
                cnt     <= CntInit;
                busy    <= 1'b1;
                if (B == '0) begin
                  // Skip the loop; FIX only signals, HI/LO are left alone.
                  dbz_pend <= 1'b1;
                  state    <= StFix;
                end else begin
                  dbz_pend <= 1'b0;
                  state    <= StRun;
                end
              end
              OpMthi:  HI <= A;
              OpMtlo:  LO <= A;
              default: ;
            endcase
          end
        end
        StRun: begin
          if (is_div) begin
            acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], q_bit};
            rem <= rem_next;
          end else begin
            acc <= {msum, acc[XLEN-1:1]};
          end
          cnt <= cnt - CntW'(1);
          if (cnt == '0) state <= StFix;
        end
        StFix: begin
          state       <= StIdle;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dbz_pend;
          if (!dbz_pend) begin
            if (is_div) begin
              HI <= rem_fix;
              LO <= quo_fix;
            end else begin
              {HI, LO} <= prod;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboarded bench for hilo_muldiv_ctrl: the stimulus side pushes expected
// HI/LO results computed with plain 64-bit arithmetic; a monitor pops and
// compares whenever done pulses.
module tb_hilo_muldiv_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  hilo_muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural effect of one operation on (hi, lo).
  function automatic exp_t ref_model(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] hi,
                                     input logic [31:0] lo);
    exp_t        e;
    logic [63:0] p;
    longint      sq;
    longint      sr;
    e.hi = hi;
    e.lo = lo;
    e.dbz = 1'b0;
    case (o)
      3'd0: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd2: begin
        if (b == 0) e.dbz = 1'b1;
        else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          e.lo = sq[31:0];
          e.hi = sr[31:0];
        end
      end
      3'd3: begin
        if (b == 0) e.dbz = 1'b1;
        else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: compare on every done pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          e = sb.pop_front();
          check("commit_hi", HI, e.hi);
          check("commit_lo", LO, e.lo);
          check("commit_dbz", div_by_zero, e.dbz);
        end
      end else if (div_by_zero) begin
        checks++;
        errors++;
        $display("FAIL dbz_without_done: got div_by_zero=1 expected 0");
      end
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    @(negedge CLK);
    n = 0;
    while (busy && n < 200) begin
      check("stall_on_start", stall, 1);
      @(negedge CLK);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got busy=1 expected 0 within 200 cycles");
    end
    if (rd_req) begin
      check("rd_idle_no_stall", stall, 0);
      check("rd_data_pre_op", rd_data, rd_sel ? m_hi : m_lo);
    end
    e = ref_model(o, a, b, m_hi, m_lo);
    if (o <= 3'd3) sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (busy || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;

    RST = 1'b1;
    start = 1'b0;
    op = '0;
    A = '0;
    B = '0;
    rd_req = 1'b0;
    rd_sel = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // Signed mult with busy-length measurement.
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    n = 0;
    @(negedge CLK);
    while (busy && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check("mult_busy_cycles", n, 33);
    check("mult_done_when_busy_falls", done, 1);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    @(posedge CLK);
    #1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0000_0000);

    // Divide by zero leaves preloaded HI/LO alone.
    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    @(negedge CLK);
    check("mthi_hi", HI, 32'h11);
    check("mtlo_lo", LO, 32'h22);
    check("mthi_not_busy", busy, 0);
    @(posedge CLK);
    #1;
    issue(3'd3, 32'd5, 32'd0);
    @(negedge CLK);
    check("dbz_busy_c1", busy, 1);
    check("dbz_no_done_c1", done, 0);
    @(negedge CLK);
    check("dbz_done_c2", done, 1);
    check("dbz_flag_c2", div_by_zero, 1);
    check("dbz_hi_kept", HI, 32'h11);
    check("dbz_lo_kept", LO, 32'h22);
    @(posedge CLK);
    #1;

    // Reserved opcode does nothing.
    issue(3'd6, 32'h1234, 32'h5678);
    @(negedge CLK);
    check("reserved_not_busy", busy, 0);
    check("reserved_hi_kept", HI, 32'h11);
    @(posedge CLK);
    #1;

    // Read held while busy stalls until the result is committed.
    issue(3'd1, 32'd3, 32'd4);
    rd_req = 1'b1;
    rd_sel = 1'b0;
    n = 0;
    @(negedge CLK);
    while (busy && n < 100) begin
      check("rd_stall_busy", stall, 1);
      n++;
      @(negedge CLK);
    end
    check("rd_unstalled", stall, 0);
    check("rd_data_new", rd_data, 32'h0000_000C);
    @(posedge CLK);
    #1 rd_req = 1'b0;

    // Second start arrives while busy and runs after done.
    issue(3'd1, 32'd5, 32'd6);
    issue(3'd0, 32'd7, 32'd8);
    wait_idle();
    check("b2b_lo", LO, 32'd56);

    // Reset in the middle of a divide.
    issue(3'd2, 32'd1000, 32'd7);
    repeat (9) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge CLK);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    repeat (40) @(negedge CLK);
    @(posedge CLK);
    #1;
    issue(3'd0, 32'd6, 32'd7);
    wait_idle();
    check("post_abort_lo", LO, 32'd42);

    // Randomized back-to-back traffic with occasional reads alongside start.
    repeat (150) begin
      rd_req = 1'($urandom_range(0, 1));
      rd_sel = 1'($urandom_range(0, 1));
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300));
      issue(o, a, b);
    end
    rd_req = 1'b0;
    wait_idle();
    check("final_hi", HI, m_hi);
    check("final_lo", LO, m_lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
